// File: rtl/ssd_page_store_pkg.sv
// Shared types for the SSD page store: controller states, command codes, error address.
// Latency: none (types and pure functions only).
// Backpressure: none.
// Contents: state_t, op_t, ADDR_INVALID, pick_op() command priority decode.
package ssd_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,   // filling the free list after reset
      ST_IDLE = 2'd1,   // waiting for a command
      ST_BUSY = 2'd2,   // modelling flash program/erase/read time
      ST_DONE = 2'd3    // one-cycle completion, also accepts a new command
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_WR   = 2'd1,
      OP_DEL  = 2'd2,
      OP_RD   = 2'd3
   } op_t;

   localparam int unsigned ADDR_W_DEF = 32;

   // Returned on addr_out when a write finds no free page.
   localparam logic [ADDR_W_DEF-1:0] ADDR_INVALID = '1;

   // Only one command is serviced per accept; delete wins over write, write over read.
   function automatic op_t pick_op(input logic wr, input logic del, input logic rd);
      op_t op;
      op = OP_NONE;
      if (del) begin
         op = OP_DEL;
      end else if (wr) begin
         op = OP_WR;
      end else if (rd) begin
         op = OP_RD;
      end
      return op;
   endfunction

endpackage

// File: rtl/ssd_page_store_fifo.sv
// Free-page list: ring of page indices handed out in the order they were returned.
// Latency: push/pop take effect at the clock edge; head is the current oldest entry.
// Backpressure: push ignored when full, pop ignored when empty; caller checks count.
// Ports: clk, rst (async, active-high), push/push_idx, pop, head, count (0..DEPTH).
module free_page_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_idx,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [W:0]   count
);

   logic [W-1:0] ring_q [DEPTH];
   logic [W-1:0] ring_d [DEPTH];
   logic [W-1:0] head_ptr_q, head_ptr_d;
   logic [W-1:0] tail_ptr_q, tail_ptr_d;
   logic [W:0]   count_q, count_d;

   logic full, empty;

   assign full  = (count_q == (W+1)'(DEPTH));
   assign empty = (count_q == '0);

   // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
   always_comb begin
      ring_d     = ring_q;
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      count_d    = count_q;
      if (push && !full) begin
         ring_d[tail_ptr_q] = push_idx;
         tail_ptr_d         = tail_ptr_q + W'(1);
         count_d            = count_d + (W+1)'(1);
      end
      if (pop && !empty) begin
         head_ptr_d = head_ptr_q + W'(1);
         count_d    = count_d - (W+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ring_q[i] <= '0;
         end
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         count_q    <= '0;
      end else begin
         ring_q     <= ring_d;
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         count_q    <= count_d;
      end
   end

   assign head  = ring_q[head_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ssd_page_store.sv
// SSD page store: allocates pages from a free list, stores/erases/reads photo pages for hash_table.
// Latency: done WRITE_LAT+1 / ERASE_LAT+1 / READ_LAT+1 cycles after accept; failed commands after 1.
// Backpressure: one command at a time; ready low while busy, commands seen with ready low are ignored.
// Ports: clk, reset (async, active-high); write/delete/read with data_in/addr_in;
//        addr_out/data_out/error qualified by done; ready; free_count (unallocated pages).
module ssd_page_store
   import ssd_pkg::*;
#(
   parameter int VALUE_SIZE = 32,
   parameter int DATA_SIZE  = 512,
   parameter int NUM_PAGES  = 16,
   parameter int WRITE_LAT  = 4,
   parameter int ERASE_LAT  = 2,
   parameter int READ_LAT   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write,
   input  logic                         delete,
   input  logic                         read,
   input  logic [DATA_SIZE-1:0]         data_in,
   input  logic [VALUE_SIZE-1:0]        addr_in,
   output logic [VALUE_SIZE-1:0]        addr_out,
   output logic [DATA_SIZE-1:0]         data_out,
   output logic                         ready,
   output logic                         done,
   output logic                         error,
   output logic [$clog2(NUM_PAGES):0]   free_count
);

   localparam int IDX_W = $clog2(NUM_PAGES);
   localparam int LAT_W = 8;
   localparam logic [VALUE_SIZE-1:0] ADDR_INV = {VALUE_SIZE{1'b1}};

   // Controller state
   state_t                 state_q, state_d;
   op_t                    op_q, op_d;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic [IDX_W-1:0]       init_q, init_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_PAGES-1:0]   valid_q, valid_d;

   // Result staged at accept, published to the outputs on entering DONE
   logic [VALUE_SIZE-1:0]  res_addr_q, res_addr_d;
   logic                   res_err_q, res_err_d;

   // Output registers: hold until the next completion
   logic [VALUE_SIZE-1:0]  addr_out_q, addr_out_d;
   logic [DATA_SIZE-1:0]   data_out_q, data_out_d;
   logic                   error_q, error_d;

   // Page storage (contents need no reset; validity lives in valid_q)
   logic [DATA_SIZE-1:0]   mem_q [NUM_PAGES];
   logic                   mem_we;
   logic [IDX_W-1:0]       mem_widx;

   // Free list interface
   logic                   fifo_push;
   logic [IDX_W-1:0]       fifo_push_idx;
   logic                   fifo_pop;
   logic [IDX_W-1:0]       fifo_head;
   logic [IDX_W:0]         fifo_count;

   op_t                    cmd;
   logic                   accept;
   logic                   addr_in_range;
   logic [IDX_W-1:0]       addr_idx;

   free_page_fifo #(
      .DEPTH (NUM_PAGES),
      .W     (IDX_W)
   ) u_free_fifo (
      .clk      (clk),
      .rst      (reset),
      .push     (fifo_push),
      .push_idx (fifo_push_idx),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .count    (fifo_count)
   );

   assign ready         = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign done          = (state_q == ST_DONE);
   assign cmd           = pick_op(write, delete, read);
   assign accept        = ready && (cmd != OP_NONE);
   assign addr_in_range = (addr_in < VALUE_SIZE'(NUM_PAGES));
   assign addr_idx      = addr_in[IDX_W-1:0];

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      lat_d         = lat_q;
      init_d        = init_q;
      idx_d         = idx_q;
      valid_d       = valid_q;
      res_addr_d    = res_addr_q;
      res_err_d     = res_err_q;
      addr_out_d    = addr_out_q;
      data_out_d    = data_out_q;
      error_d       = error_q;
      mem_we        = 1'b0;
      mem_widx      = fifo_head;
      fifo_push     = 1'b0;
      fifo_push_idx = init_q;
      fifo_pop      = 1'b0;

      case (state_q)
         ST_INIT: begin
            // One index per cycle, so the free list comes out 0,1,2,... after reset
            fifo_push     = 1'b1;
            fifo_push_idx = init_q;
            init_d        = init_q + IDX_W'(1);
            if (init_q == IDX_W'(NUM_PAGES - 1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (lat_q == '0) begin
               state_d    = ST_DONE;
               addr_out_d = res_addr_q;
               error_d    = res_err_q;
               if (op_q == OP_RD) begin
                  data_out_d = res_err_q ? '0 : mem_q[idx_q];
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Accept overrides the IDLE/DONE next state; bookkeeping is committed at the accept edge
      if (accept) begin
         state_d    = ST_BUSY;
         op_d       = cmd;
         res_addr_d = addr_in;
         res_err_d  = 1'b0;
         idx_d      = addr_idx;
         case (cmd)
            OP_WR: begin
               if (fifo_count == '0) begin
                  res_err_d  = 1'b1;
                  res_addr_d = ADDR_INV;
                  lat_d      = '0;
               end else begin
                  fifo_pop          = 1'b1;
                  mem_we            = 1'b1;
                  mem_widx          = fifo_head;
                  valid_d[fifo_head] = 1'b1;
                  idx_d             = fifo_head;
                  res_addr_d        = VALUE_SIZE'(fifo_head);
                  lat_d             = LAT_W'(WRITE_LAT);
               end
            end
            OP_DEL: begin
               if (!addr_in_range || !valid_q[addr_idx]) begin
                  res_err_d = 1'b1;
                  lat_d     = '0;
               end else begin
                  valid_d[addr_idx] = 1'b0;
                  fifo_push         = 1'b1;
                  fifo_push_idx     = addr_idx;
                  lat_d             = LAT_W'(ERASE_LAT);
               end
            end
            OP_RD: begin
               if (!addr_in_range || !valid_q[addr_idx]) begin
                  res_err_d = 1'b1;
                  lat_d     = '0;
               end else begin
                  lat_d = LAT_W'(READ_LAT);
               end
            end
            default: begin
               res_err_d = 1'b1;
               lat_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_INIT;
         op_q       <= OP_NONE;
         lat_q      <= '0;
         init_q     <= '0;
         idx_q      <= '0;
         valid_q    <= '0;
         res_addr_q <= '0;
         res_err_q  <= 1'b0;
         addr_out_q <= '0;
         data_out_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         lat_q      <= lat_d;
         init_q     <= init_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         res_addr_q <= res_addr_d;
         res_err_q  <= res_err_d;
         addr_out_q <= addr_out_d;
         data_out_q <= data_out_d;
         error_q    <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_widx] <= data_in;
      end
   end

   assign addr_out   = addr_out_q;
   assign data_out   = data_out_q;
   assign error      = error_q;
   assign free_count = fifo_count;

endmodule

// File: tb/tb_ssd_page_store.sv
// Bench for ssd_page_store: directed commands push expected completions into a queue,
// a negedge monitor pops and compares on every done pulse (address, error, data, latency, free_count).
// Clock period 10; inputs driven on negedges.
module tb_ssd_page_store;

   logic         clk;
   logic         reset;
   logic         write;
   logic         delete;
   logic         read;
   logic [511:0] data_in;
   logic [31:0]  addr_in;
   logic [31:0]  addr_out;
   logic [511:0] data_out;
   logic         ready;
   logic         done;
   logic         error;
   logic [4:0]   free_count;

   typedef struct {
      string        name;
      logic [31:0]  addr;
      logic         err;
      logic         chk_data;
      logic [511:0] data;
      int           edges;
      int           fc;
      int           t_issue;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   n_chk   = 0;
   int   n_pass  = 0;

   ssd_page_store dut (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .delete     (delete),
      .read       (read),
      .data_in    (data_in),
      .addr_in    (addr_in),
      .addr_out   (addr_out),
      .data_out   (data_out),
      .ready      (ready),
      .done       (done),
      .error      (error),
      .free_count (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endfunction

   function automatic exp_t mk(input string nm, input logic [31:0] a, input logic e,
                               input logic cd, input logic [511:0] d, input int edges, input int fc);
      exp_t x;
      x.name = nm; x.addr = a; x.err = e; x.chk_data = cd; x.data = d;
      x.edges = edges; x.fc = fc; x.t_issue = 0;
      return x;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, "_addr"}, addr_out, e.addr);
            chk({e.name, "_err"}, error, e.err);
            if (e.chk_data) chk({e.name, "_data"}, data_out, e.data);
            chk({e.name, "_lat"}, cyc - (e.t_issue + 1), e.edges);
            chk({e.name, "_fc"}, free_count, e.fc);
         end
      end
   end

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk({nm, "_ready_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic do_cmd(input logic w, input logic dl, input logic rd, input logic [31:0] a,
                         input logic [511:0] di, input exp_t e);
      int n;
      wait_ready(e.name);
      e.t_issue = cyc;
      exp_q.push_back(e);
      write = w; delete = dl; read = rd; addr_in = a; data_in = di;
      @(negedge clk);
      write = 1'b0; delete = 1'b0; read = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk({e.name, "_done_timeout"}, 1'b0, 1'b1);
         exp_q.delete();
      end
   endtask

   // Counts negedges with ready low, starting at the reset-release negedge
   task automatic check_init(input string nm);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk({nm, "_init_cycles"}, n, 16);
      chk({nm, "_init_fc"}, free_count, 16);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; write = 1'b0; delete = 1'b0; read = 1'b0;
      data_in = '0; addr_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_addr_out", addr_out, 32'h0);
      chk("rst_data_out", data_out, 512'h0);
      chk("rst_fc", free_count, 5'd0);
      reset = 1'b0;
      check_init("boot");

      // Fill every page: allocation order 0..15, WRITE_LAT+1 = 5 cycles each
      for (int i = 0; i < 16; i++) begin
         do_cmd(1, 0, 0, 32'h0, 512'(i * 16), mk($sformatf("wr%0d", i), 32'(i), 0, 0, '0, 5, 15 - i));
      end
      do_cmd(1, 0, 0, 32'h0, 512'h77, mk("wr_full", 32'hFFFF_FFFF, 1, 0, '0, 1, 0));
      do_cmd(0, 0, 1, 32'd3, '0, mk("rd3", 32'd3, 0, 1, 512'h30, 2, 0));
      do_cmd(0, 1, 0, 32'd5, '0, mk("del5", 32'd5, 0, 0, '0, 3, 1));
      do_cmd(1, 0, 0, 32'h0, 512'hABC, mk("wr_reuse5", 32'd5, 0, 0, '0, 5, 0));
      do_cmd(0, 0, 1, 32'd5, '0, mk("rd5_new", 32'd5, 0, 1, 512'hABC, 2, 0));
      do_cmd(0, 1, 0, 32'd5, '0, mk("del5_again", 32'd5, 0, 0, '0, 3, 1));
      do_cmd(0, 0, 1, 32'd5, '0, mk("rd5_freed", 32'd5, 1, 1, 512'h0, 1, 1));
      do_cmd(0, 1, 0, 32'd20, '0, mk("del20", 32'd20, 1, 0, '0, 1, 1));
      do_cmd(0, 1, 0, 32'd5, '0, mk("del_free5", 32'd5, 1, 0, '0, 1, 1));
      do_cmd(0, 0, 1, 32'd99, '0, mk("rd99", 32'd99, 1, 1, 512'h0, 1, 1));
      // write+delete together: delete of 7 wins, write is dropped
      do_cmd(1, 1, 0, 32'd7, 512'h99, mk("wr_del7", 32'd7, 0, 0, '0, 3, 2));
      do_cmd(0, 0, 1, 32'd7, '0, mk("rd7_freed", 32'd7, 1, 1, 512'h0, 1, 2));
      // Free list now holds 5 then 7
      do_cmd(1, 0, 0, 32'h0, 512'h123, mk("wr_fifo5", 32'd5, 0, 0, '0, 5, 1));
      do_cmd(1, 0, 0, 32'h0, 512'h456, mk("wr_fifo7", 32'd7, 0, 0, '0, 5, 0));
      do_cmd(0, 0, 1, 32'd7, '0, mk("rd7_new", 32'd7, 0, 1, 512'h456, 2, 0));

      // Reset two cycles into a write: no completion, full re-init
      do_cmd(0, 1, 0, 32'd0, '0, mk("del0", 32'd0, 0, 0, '0, 3, 1));
      wait_ready("abort");
      write = 1'b1; data_in = 512'hDEAD;
      @(negedge clk);
      write = 1'b0;
      chk("abort_done_c1", done, 1'b0);
      @(negedge clk);
      chk("abort_done_c2", done, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_rst_done", done, 1'b0);
      chk("abort_rst_fc", free_count, 5'd0);
      @(negedge clk);
      reset = 1'b0;
      check_init("reinit");
      do_cmd(1, 0, 0, 32'h0, 512'h55, mk("wr_after_rst", 32'd0, 0, 0, '0, 5, 15));
      do_cmd(0, 0, 1, 32'd0, '0, mk("rd0_after_rst", 32'd0, 0, 1, 512'h55, 2, 15));
      do_cmd(0, 0, 1, 32'd1, '0, mk("rd1_after_rst", 32'd1, 1, 1, 512'h0, 1, 15));

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
